// File: rtl/prism_evt_timer_shift.sv
// prism_evt_timer_shift: PRISM event down-counters,
// serial shifter and word FIFO on the TinyQV bus.
module prism_evt_timer_shift #(
  parameter int NCNT       = 2,
  parameter int CNT_W      = 24,
  parameter int SHIFT_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  input  logic [NCNT-1:0]   cnt_load,
  input  logic [NCNT-1:0]   cnt_dec,
  input  logic              shift_en,
  input  logic [3:0]        shift_in,
  output logic [NCNT-1:0]   cnt_zero,
  output logic              shift_out,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(SHIFT_W);
  localparam int LW = AW + 1;
  localparam logic [BW-1:0] B_LAST =
    BW'(SHIFT_W - 1);
  localparam logic [LW-1:0] L_FULL =
    LW'(FIFO_DEPTH);

  // control / status state
  logic              en_q;
  logic              dir_q;
  logic [1:0]        sel_q;
  logic [NCNT-1:0]   ar_q;
  logic [NCNT-1:0]   zs_q;
  logic              wd_q;
  logic              ovf_q;
  logic [9:0]        ien_q;
  logic              irq_q;

  // counters
  logic [CNT_W-1:0]  cnt_q [NCNT];
  logic [CNT_W-1:0]  pre_q [NCNT];
  logic [CNT_W-1:0]  cnt_d [NCNT];
  logic [NCNT-1:0]   zs_set;

  // shifter
  logic [SHIFT_W-1:0] sr_q;
  logic [SHIFT_W-1:0] sr_d;
  logic [SHIFT_W-1:0] sr_sh;
  logic [BW-1:0]      bc_q;
  logic [BW-1:0]      bc_d;
  logic               sbit;
  logic               shift;
  logic               word;

  // fifo
  logic [SHIFT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wp_q;
  logic [AW-1:0]      rp_q;
  logic [LW-1:0]      lvl_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               drop;

  // bus decode
  logic              wr;
  logic              rd;
  logic              al;
  logic [3:0]        wa;
  logic              is_ctrl;
  logic              is_stat;
  logic              is_ien;
  logic              is_fifo;
  logic              is_cnt;
  logic              wr_ctrl;
  logic              wr_stat;
  logic              wr_ien;
  logic              wr_cnt;
  logic              flush;
  logic              unused_ok;

  // read-side views
  logic [CNT_W-1:0]  cnt_rd;
  logic [9:0]        stat10;
  logic [2:0]        lvl3;
  logic [31:0]       ctrl_rd;
  logic [31:0]       stat_rd;
  logic [31:0]       fifo_rd;

  assign data_ready = 1'b1;
  assign unused_ok  = ^data_in;

  assign wr = (data_write_n == 2'b10);
  assign rd = (data_read_n != 2'b11);
  assign al = (address[1:0] == 2'b00);
  assign wa = address[5:2];

  assign is_ctrl = al && (wa == 4'd0);
  assign is_stat = al && (wa == 4'd1);
  assign is_ien  = al && (wa == 4'd2);
  assign is_fifo = al && (wa == 4'd3);
  assign is_cnt  = al && (wa[3:2] == 2'b01)
                 && (int'(wa[1:0]) < NCNT);

  assign wr_ctrl = wr && is_ctrl;
  assign wr_stat = wr && is_stat;
  assign wr_ien  = wr && is_ien;
  assign wr_cnt  = wr && is_cnt;
  assign flush   = wr_ctrl && data_in[31];

  // counter next state: load beats dec
  always_comb begin
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k]  = cnt_q[k];
      zs_set[k] = 1'b0;
      if (en_q) begin
        if (cnt_load[k]) begin
          cnt_d[k] = pre_q[k];
        end else if (cnt_dec[k]) begin
          if (cnt_q[k] == '0) begin
            cnt_d[k] = ar_q[k] ? pre_q[k]
                               : '0;
          end else if (cnt_q[k] == CNT_W'(1)) begin
            cnt_d[k]  = '0;
            zs_set[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] - CNT_W'(1);
          end
        end
      end
    end
  end

  // shifter next state and word completion
  always_comb begin
    sbit  = shift_in[sel_q];
    shift = en_q && shift_en;
    sr_sh = dir_q
      ? {sbit, sr_q[SHIFT_W-1:1]}
      : {sr_q[SHIFT_W-2:0], sbit};
    sr_d  = shift ? sr_sh : sr_q;
    word  = shift && (bc_q == B_LAST);
    bc_d  = bc_q;
    if (flush)
      bc_d = '0;
    else if (word)
      bc_d = '0;
    else if (shift)
      bc_d = bc_q + BW'(1);
  end

  // fifo push/pop arbitration
  always_comb begin
    full  = (lvl_q == L_FULL);
    empty = (lvl_q == '0);
    pop   = rd && is_fifo && !empty;
    push  = word && (!full || pop);
    drop  = word && full && !pop;
  end

  // counter and preload registers
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCNT; k++) begin
      if (!rst_n) begin
        cnt_q[k] <= '0;
        pre_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
        if (wr_cnt && (wa[1:0] == 2'(k)))
          pre_q[k] <= data_in[CNT_W-1:0];
      end
    end
  end

  // control, mask, sticky status and irq
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      dir_q <= 1'b0;
      sel_q <= 2'b00;
      ar_q  <= '0;
      ien_q <= '0;
      zs_q  <= '0;
      wd_q  <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q  <= data_in[0];
        dir_q <= data_in[1];
        sel_q <= data_in[3:2];
        ar_q  <= data_in[8 +: NCNT];
      end
      if (wr_ien)
        ien_q <= data_in[9:0];
      zs_q  <= (zs_q & ~({NCNT{wr_stat}}
             & data_in[NCNT-1:0])) | zs_set;
      wd_q  <= (wd_q & ~(wr_stat && data_in[8]))
             | word;
      ovf_q <= (ovf_q & ~(wr_stat && data_in[9]))
             | drop;
      irq_q <= |(stat10 & ien_q);
    end
  end

  // shift register and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
      bc_q <= '0;
    end else begin
      sr_q <= sr_d;
      bc_q <= bc_d;
    end
  end

  // fifo storage and pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) begin
        mem[wp_q] <= sr_d;
        wp_q      <= wp_q + AW'(1);
      end
      if (pop)
        rp_q <= rp_q + AW'(1);
      lvl_q <= lvl_q + LW'(push) - LW'(pop);
    end
  end

  // read views of the register map
  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < NCNT; k++)
      if (wa[1:0] == 2'(k))
        cnt_rd = cnt_q[k];
    stat10 = '0;
    stat10[NCNT-1:0] = zs_q;
    stat10[8] = wd_q;
    stat10[9] = ovf_q;
    lvl3 = 3'(lvl_q);
    ctrl_rd = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = dir_q;
    ctrl_rd[3:2] = sel_q;
    ctrl_rd[8 +: NCNT] = ar_q;
    stat_rd = '0;
    stat_rd[9:0] = stat10;
    stat_rd[10] = !empty;
    stat_rd[13:11] = lvl3;
    fifo_rd = empty ? '0 : 32'(mem[rp_q]);
  end

  // address-selected read data
  always_comb begin
    data_out = '0;
    unique case (1'b1)
      is_ctrl: data_out = ctrl_rd;
      is_stat: data_out = stat_rd;
      is_ien:  data_out = {22'd0, ien_q};
      is_fifo: data_out = fifo_rd;
      is_cnt:  data_out = 32'(cnt_rd);
      default: data_out = '0;
    endcase
  end

  // event-side outputs
  always_comb begin
    for (int k = 0; k < NCNT; k++)
      cnt_zero[k] = (cnt_q[k] == '0);
    shift_out = dir_q ? sr_q[0]
                      : sr_q[SHIFT_W-1];
    irq = irq_q;
  end

endmodule

// File: tb/tb_prism_evt_timer_shift.sv
// tb_prism_evt_timer_shift: directed vectors for
// counters, shifter, fifo and irq of the PRISM block.
module tb_prism_evt_timer_shift;

  localparam logic [5:0] A_CTRL = 6'h00;
  localparam logic [5:0] A_STAT = 6'h04;
  localparam logic [5:0] A_IEN  = 6'h08;
  localparam logic [5:0] A_FIFO = 6'h0C;
  localparam logic [5:0] A_CNT0 = 6'h10;
  localparam logic [5:0] A_CNT1 = 6'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic [1:0]  cnt_load = '0;
  logic [1:0]  cnt_dec = '0;
  logic        shift_en = 1'b0;
  logic [3:0]  shift_in = '0;
  logic [1:0]  cnt_zero;
  logic        shift_out;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;
  int n_app = 0;

  prism_evt_timer_shift dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .cnt_load     (cnt_load),
    .cnt_dec      (cnt_dec),
    .shift_en     (shift_en),
    .shift_in     (shift_in),
    .cnt_zero     (cnt_zero),
    .shift_out    (shift_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wd;
    logic        wr;
    logic        rd;
    logic [1:0]  ld;
    logic [1:0]  dec;
    logic        sh;
    logic [3:0]  sin;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        chk_irq;
    logic        exp_irq;
    logic        chk_z;
    logic [1:0]  exp_z;
    logic        chk_so;
    logic        exp_so;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [5:0]  a,
    input logic [31:0] wd,
    input logic        wr,
    input logic        rd
  );
    vec_t t;
    t.addr = a; t.wd = wd;
    t.wr = wr; t.rd = rd;
    t.ld = '0; t.dec = '0;
    t.sh = 1'b0; t.sin = '0;
    t.chk_d = 1'b0; t.exp_d = '0;
    t.chk_irq = 1'b0; t.exp_irq = 1'b0;
    t.chk_z = 1'b0; t.exp_z = '0;
    t.chk_so = 1'b0; t.exp_so = 1'b0;
    return t;
  endfunction

  function automatic vec_t wv(
    input logic [5:0] a, input logic [31:0] d
  );
    return mk(a, d, 1'b1, 1'b0);
  endfunction

  function automatic vec_t rv(
    input logic [5:0] a, input logic [31:0] e
  );
    vec_t t;
    t = mk(a, 32'd0, 1'b0, 1'b1);
    t.chk_d = 1'b1;
    t.exp_d = e;
    return t;
  endfunction

  function automatic vec_t idle();
    return mk(A_CTRL, 32'd0, 1'b0, 1'b0);
  endfunction

  // one shift with bit b on input sel, others inverted
  function automatic vec_t sv(
    input logic b, input int sel
  );
    vec_t t;
    logic [3:0] m;
    t = idle();
    m = 4'b0001 << sel;
    t.sh = 1'b1;
    t.sin = b ? m : ~m;
    return t;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h want %h",
               n_app, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    address = t.addr;
    data_in = t.wd;
    data_write_n = t.wr ? 2'b10 : 2'b11;
    data_read_n = t.rd ? 2'b00 : 2'b11;
    cnt_load = t.ld;
    cnt_dec = t.dec;
    shift_en = t.sh;
    shift_in = t.sin;
    #1;
    if (t.chk_d)
      chk("data_out", data_out, t.exp_d);
    if (t.chk_irq)
      chk("irq", 32'(irq), 32'(t.exp_irq));
    if (t.chk_z)
      chk("cnt_zero", 32'(cnt_zero), 32'(t.exp_z));
    if (t.chk_so)
      chk("shift_out", 32'(shift_out),
          32'(t.exp_so));
    @(posedge clk);
    n_app++;
  endtask

  task automatic shift_word(
    input logic [7:0]  w,
    input int          sel,
    input logic        pop_last,
    input logic [31:0] exp_pop
  );
    vec_t t;
    for (int i = 7; i >= 0; i--) begin
      t = sv(w[i], sel);
      if (i == 0 && pop_last) begin
        t.addr = A_FIFO;
        t.rd = 1'b1;
        t.chk_d = 1'b1;
        t.exp_d = exp_pop;
      end
      apply(t);
    end
  endtask

  initial begin
    vec_t t;
    logic [7:0] sr_m;
    logic b;

    // reset state
    t = rv(A_CTRL, 32'h0);
    t.chk_z = 1'b1; t.exp_z = 2'b11;
    t.chk_irq = 1'b1; t.exp_irq = 1'b0;
    t.chk_so = 1'b1; t.exp_so = 1'b0;
    tbl.push_back(t);
    tbl.push_back(rv(A_STAT, 32'h0));
    tbl.push_back(rv(A_CNT0, 32'h0));
    tbl.push_back(rv(A_IEN, 32'h0));
    tbl.push_back(rv(A_FIFO, 32'h0));

    // counter 0 countdown, sticky and irq
    tbl.push_back(wv(A_CNT0, 32'd3));
    tbl.push_back(rv(A_CNT0, 32'd0));
    tbl.push_back(wv(A_CTRL, 32'h1));
    t = rv(A_CNT0, 32'd0); t.ld = 2'b01;
    tbl.push_back(t);
    t = rv(A_CNT0, 32'd3); t.dec = 2'b01;
    tbl.push_back(t);
    t = rv(A_CNT0, 32'd2); t.dec = 2'b01;
    tbl.push_back(t);
    t = rv(A_CNT0, 32'd1); t.dec = 2'b01;
    t.chk_z = 1'b1; t.exp_z = 2'b10;
    tbl.push_back(t);
    t = rv(A_CNT0, 32'd0);
    t.chk_z = 1'b1; t.exp_z = 2'b11;
    tbl.push_back(t);
    tbl.push_back(rv(A_STAT, 32'h1));
    t = wv(A_IEN, 32'h1);
    t.chk_irq = 1'b1; t.exp_irq = 1'b0;
    tbl.push_back(t);
    t = idle();
    t.chk_irq = 1'b1; t.exp_irq = 1'b0;
    tbl.push_back(t);
    t = wv(A_STAT, 32'h1);
    t.chk_irq = 1'b1; t.exp_irq = 1'b1;
    tbl.push_back(t);
    t = rv(A_STAT, 32'h0);
    t.chk_irq = 1'b1; t.exp_irq = 1'b1;
    tbl.push_back(t);
    t = idle();
    t.chk_irq = 1'b1; t.exp_irq = 1'b0;
    tbl.push_back(t);

    // counter 1 autoreload, load beats dec
    tbl.push_back(wv(A_CTRL, 32'h201));
    tbl.push_back(wv(A_CNT1, 32'd2));
    t = rv(A_CNT1, 32'd0); t.dec = 2'b10;
    tbl.push_back(t);
    t = rv(A_CNT1, 32'd2);
    t.ld = 2'b10; t.dec = 2'b10;
    tbl.push_back(t);
    t = rv(A_CNT1, 32'd2);
    t.chk_z = 1'b1; t.exp_z = 2'b01;
    tbl.push_back(t);
    tbl.push_back(rv(A_STAT, 32'h0));
    tbl.push_back(rv(A_CTRL, 32'h201));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // MSB-first word on input 2
    apply(wv(A_CTRL, 32'h9));
    shift_word(8'hA5, 2, 1'b0, 32'd0);
    apply(rv(A_STAT, 32'h0D00));
    apply(rv(A_FIFO, 32'hA5));
    apply(rv(A_FIFO, 32'h0));
    apply(rv(A_STAT, 32'h0100));

    // LSB-first word, shift_out tracks LSB
    apply(wv(A_STAT, 32'h100));
    apply(wv(A_CTRL, 32'hB));
    sr_m = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      b = (i == 0);
      t = sv(b, 2);
      t.chk_so = 1'b1;
      t.exp_so = sr_m[0];
      apply(t);
      sr_m = {b, sr_m[7:1]};
    end
    t = idle();
    t.chk_so = 1'b1; t.exp_so = sr_m[0];
    apply(t);
    apply(rv(A_FIFO, 32'h01));

    // fifo overflow, then full push+pop
    apply(wv(A_CTRL, 32'h1));
    apply(wv(A_STAT, 32'h300));
    for (int w = 1; w <= 5; w++)
      shift_word(8'(w), 0, 1'b0, 32'd0);
    apply(rv(A_STAT, 32'h2700));
    for (int w = 1; w <= 4; w++)
      apply(rv(A_FIFO, 32'(w)));
    apply(rv(A_STAT, 32'h0300));
    for (int w = 6; w <= 9; w++)
      shift_word(8'(w), 0, 1'b0, 32'd0);
    apply(wv(A_STAT, 32'h300));
    apply(rv(A_STAT, 32'h2400));
    shift_word(8'd10, 0, 1'b1, 32'd6);
    apply(rv(A_STAT, 32'h2500));
    for (int w = 7; w <= 10; w++)
      apply(rv(A_FIFO, 32'(w)));

    // en=0 freezes counters and shifter
    apply(sv(1'b1, 0));
    apply(sv(1'b0, 0));
    apply(sv(1'b1, 0));
    apply(sv(1'b1, 0));
    apply(wv(A_CTRL, 32'h0));
    for (int i = 0; i < 4; i++) begin
      t = rv(A_CNT1, 32'd2);
      t.ld = 2'b11; t.dec = 2'b11;
      t.sh = 1'b1; t.sin = 4'b0000;
      t.chk_so = 1'b1; t.exp_so = 1'b1;
      apply(t);
    end
    apply(rv(A_CNT0, 32'd0));
    apply(wv(A_CTRL, 32'h1));
    apply(sv(1'b0, 0));
    apply(sv(1'b1, 0));
    apply(sv(1'b0, 0));
    apply(sv(1'b1, 0));
    apply(rv(A_FIFO, 32'hB5));

    // flush mid-word
    shift_word(8'h11, 0, 1'b0, 32'd0);
    apply(sv(1'b1, 0));
    apply(sv(1'b1, 0));
    apply(sv(1'b1, 0));
    apply(wv(A_CTRL, 32'h8000_0001));
    apply(rv(A_STAT, 32'h0100));
    apply(rv(A_CTRL, 32'h1));
    shift_word(8'h3C, 0, 1'b0, 32'd0);
    apply(rv(A_STAT, 32'h0D00));
    apply(rv(A_FIFO, 32'h3C));
    apply(rv(A_FIFO, 32'h0));

    // reset mid-count
    apply(wv(A_CNT0, 32'd5));
    t = idle(); t.ld = 2'b01;
    apply(t);
    apply(rv(A_CNT0, 32'd5));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = rv(A_CNT0, 32'd0);
    t.chk_z = 1'b1; t.exp_z = 2'b11;
    apply(t);
    apply(rv(A_CTRL, 32'h0));
    apply(rv(A_STAT, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
